// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared phase enum, 640x480 constants and sizing helpers for the VGA timing generator
package vga_timing_pkg;

    // Four-phase sequence shared by the horizontal and vertical axes.
    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SYN = 2'd2,
        PH_BP  = 2'd3
    } phase_e;

    // 640x480 @ 60 Hz timing.
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Length of the given phase in steps.
    function automatic int phase_len(input phase_e ph, input int l_act, input int l_fp,
                                     input int l_syn, input int l_bp);
        phase_len = l_bp;
        case (ph)
            PH_ACT:  phase_len = l_act;
            PH_FP:   phase_len = l_fp;
            PH_SYN:  phase_len = l_syn;
            default: phase_len = l_bp;
        endcase
    endfunction

    // Counter width able to hold the longest phase without overflow.
    function automatic int count_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        count_width = $clog2(m + 1);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - four-phase counter for one VGA axis (ACT/FP/SYN/BP)
//
// Ports:
//   Clock, Reset  system clock, synchronous active-high reset
//   step_i        advance one unit (pixel or line)
//   phase_o       current phase
//   count_o       position inside the current phase, restarts at 0 on each phase change
//   wrap_o        combinational: this step leaves the last unit of PH_BP
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int L_ACT = 640,
    parameter int L_FP  = 16,
    parameter int L_SYN = 96,
    parameter int L_BP  = 48,
    parameter int CW    = count_width(L_ACT, L_FP, L_SYN, L_BP)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          step_i,
    output phase_e        phase_o,
    output logic [CW-1:0] count_o,
    output logic          wrap_o
);

    phase_e        phase_q, phase_d;
    logic [CW-1:0] count_q, count_d;
    logic          last;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase_q <= PH_ACT;
            count_q <= '0;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        last    = (count_q == CW'(phase_len(phase_q, L_ACT, L_FP, L_SYN, L_BP) - 1));
        wrap_o  = step_i && last && (phase_q == PH_BP);
        if (step_i) begin
            if (last) begin
                count_d = '0;
                case (phase_q)
                    PH_ACT:  phase_d = PH_FP;
                    PH_FP:   phase_d = PH_SYN;
                    PH_SYN:  phase_d = PH_BP;
                    default: phase_d = PH_ACT;
                endcase
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign phase_o = phase_q;
    assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with pixel prescaler and scaled memory addresses
//
// Ports:
//   Clock, Reset          system clock, synchronous active-high reset
//   oVGAHorizontalSync    HS_POL during horizontal sync, ~HS_POL otherwise
//   oVGAVerticalSync      VS_POL during vertical sync lines, ~VS_POL otherwise
//   oVideoActive          pixel lies in both active regions
//   oVideoMemCol/Row      pixel coordinate >> SCALE_SHIFT (zero outside active)
//   oPixelTick            first Clock of each pixel
//   oLineStart            first Clock of pixel 0 of every line
//   oFrameStart           first Clock of pixel (0,0) of every frame
// All outputs are registered.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   H_FP        = VGA_H_FP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BP        = VGA_H_BP,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   V_FP        = VGA_V_FP,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BP        = VGA_V_BP,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   CLK_DIV     = 2,
    parameter int   SCALE_SHIFT = 0,
    parameter int   X_WIDTH     = 8,
    parameter int   Y_WIDTH     = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic               oVGAHorizontalSync,
    output logic               oVGAVerticalSync,
    output logic               oVideoActive,
    output logic [X_WIDTH-1:0] oVideoMemCol,
    output logic [Y_WIDTH-1:0] oVideoMemRow,
    output logic               oPixelTick,
    output logic               oLineStart,
    output logic               oFrameStart
);

    localparam int HCW = count_width(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VCW = count_width(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0]  presc_q;
    logic           pix_step, pix_first;
    phase_e         h_phase, v_phase;
    logic [HCW-1:0] h_count;
    logic [VCW-1:0] v_count;
    logic           h_wrap, v_wrap;

    // Set by the step that wraps an axis (and by reset), so they are high
    // exactly on the first Clock of the following pixel (0) / (0,0).
    logic line_pend_q, frame_pend_q;

    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               active_q, active_d;
    logic [X_WIDTH-1:0] col_q, col_d;
    logic [Y_WIDTH-1:0] row_q, row_d;
    logic               tick_q, line_q, frame_q;

    assign pix_step  = (presc_q == PW'(CLK_DIV - 1));
    assign pix_first = (presc_q == '0);

    always_ff @(posedge Clock) begin
        if (Reset || pix_step) presc_q <= '0;
        else                   presc_q <= presc_q + 1'b1;
    end

    vga_axis_counter #(
        .L_ACT(H_ACTIVE), .L_FP(H_FP), .L_SYN(H_SYNC), .L_BP(H_BP), .CW(HCW)
    ) u_h (
        .Clock  (Clock),
        .Reset  (Reset),
        .step_i (pix_step),
        .phase_o(h_phase),
        .count_o(h_count),
        .wrap_o (h_wrap)
    );

    vga_axis_counter #(
        .L_ACT(V_ACTIVE), .L_FP(V_FP), .L_SYN(V_SYNC), .L_BP(V_BP), .CW(VCW)
    ) u_v (
        .Clock  (Clock),
        .Reset  (Reset),
        .step_i (h_wrap),
        .phase_o(v_phase),
        .count_o(v_count),
        .wrap_o (v_wrap)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            line_pend_q  <= 1'b1;
            frame_pend_q <= 1'b1;
        end else begin
            line_pend_q  <= h_wrap;
            frame_pend_q <= v_wrap;
        end
    end

    always_comb begin
        hsync_d  = (h_phase == PH_SYN) ? HS_POL : ~HS_POL;
        vsync_d  = (v_phase == PH_SYN) ? VS_POL : ~VS_POL;
        active_d = (h_phase == PH_ACT) && (v_phase == PH_ACT);
        col_d    = '0;
        row_d    = '0;
        if (active_d)          col_d = X_WIDTH'(h_count >> SCALE_SHIFT);
        if (v_phase == PH_ACT) row_d = Y_WIDTH'(v_count >> SCALE_SHIFT);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            active_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            tick_q   <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            col_q    <= col_d;
            row_q    <= row_d;
            tick_q   <= pix_first;
            line_q   <= line_pend_q;
            frame_q  <= frame_pend_q;
        end
    end

    assign oVGAHorizontalSync = hsync_q;
    assign oVGAVerticalSync   = vsync_q;
    assign oVideoActive       = active_q;
    assign oVideoMemCol       = col_q;
    assign oVideoMemRow       = row_q;
    assign oPixelTick         = tick_q;
    assign oLineStart         = line_q;
    assign oFrameStart        = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic Clock;
    logic Reset;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // a: small CLK_DIV=1 pol0; b: small CLK_DIV=3; c: small pol1; d: 640x480 div2 shift2
    logic a_hs, a_vs, a_act, a_tick, a_ls, a_fs; logic [7:0] a_col, a_row;
    logic b_hs, b_vs, b_act, b_tick, b_ls, b_fs; logic [7:0] b_col, b_row;
    logic c_hs, c_vs, c_act, c_tick, c_ls, c_fs; logic [7:0] c_col, c_row;
    logic d_hs, d_vs, d_act, d_tick, d_ls, d_fs; logic [7:0] d_col, d_row;

    logic [21:0] out_a, out_b, out_c, out_d;
    assign out_a = {a_hs, a_vs, a_act, a_col, a_row, a_tick, a_ls, a_fs};
    assign out_b = {b_hs, b_vs, b_act, b_col, b_row, b_tick, b_ls, b_fs};
    assign out_c = {c_hs, c_vs, c_act, c_col, c_row, c_tick, c_ls, c_fs};
    assign out_d = {d_hs, d_vs, d_act, d_col, d_row, d_tick, d_ls, d_fs};

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .SCALE_SHIFT(0),
        .X_WIDTH(8), .Y_WIDTH(8)) u_a (
        .Clock(Clock), .Reset(Reset), .oVGAHorizontalSync(a_hs), .oVGAVerticalSync(a_vs),
        .oVideoActive(a_act), .oVideoMemCol(a_col), .oVideoMemRow(a_row),
        .oPixelTick(a_tick), .oLineStart(a_ls), .oFrameStart(a_fs));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3), .SCALE_SHIFT(0),
        .X_WIDTH(8), .Y_WIDTH(8)) u_b (
        .Clock(Clock), .Reset(Reset), .oVGAHorizontalSync(b_hs), .oVGAVerticalSync(b_vs),
        .oVideoActive(b_act), .oVideoMemCol(b_col), .oVideoMemRow(b_row),
        .oPixelTick(b_tick), .oLineStart(b_ls), .oFrameStart(b_fs));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .SCALE_SHIFT(0),
        .X_WIDTH(8), .Y_WIDTH(8)) u_c (
        .Clock(Clock), .Reset(Reset), .oVGAHorizontalSync(c_hs), .oVGAVerticalSync(c_vs),
        .oVideoActive(c_act), .oVideoMemCol(c_col), .oVideoMemRow(c_row),
        .oPixelTick(c_tick), .oLineStart(c_ls), .oFrameStart(c_fs));

    vga_timing_gen #(.CLK_DIV(2), .SCALE_SHIFT(2), .X_WIDTH(8), .Y_WIDTH(8)) u_d (
        .Clock(Clock), .Reset(Reset), .oVGAHorizontalSync(d_hs), .oVGAVerticalSync(d_vs),
        .oVideoActive(d_act), .oVideoMemCol(d_col), .oVideoMemRow(d_row),
        .oPixelTick(d_tick), .oLineStart(d_ls), .oFrameStart(d_fs));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Expected output vector k samples after reset release, from frame arithmetic.
    function automatic logic [21:0] model(input int k, input int div, input int ha, input int hf,
        input int hs, input int hb, input int va, input int vf, input int vs, input int vb,
        input logic hpol, input logic vpol, input int sh);
        int pix, hl, vl, fp, x, y;
        logic hact, vact, first, hso, vso, ls, fs;
        logic [7:0] col, row;
        pix   = k / div;
        hl    = ha + hf + hs + hb;
        vl    = va + vf + vs + vb;
        fp    = pix % (hl * vl);
        x     = fp % hl;
        y     = fp / hl;
        hact  = (x < ha);
        vact  = (y < va);
        first = ((k % div) == 0);
        hso   = (x >= ha + hf && x < ha + hf + hs) ? hpol : ~hpol;
        vso   = (y >= va + vf && y < va + vf + vs) ? vpol : ~vpol;
        col   = (hact && vact) ? 8'(x >> sh) : 8'd0;
        row   = vact ? 8'(y >> sh) : 8'd0;
        ls    = first && (x == 0);
        fs    = first && (fp == 0);
        return {hso, vso, hact && vact, col, row, first, ls, fs};
    endfunction

    localparam logic [21:0] RST_P0 = {2'b11, 20'd0};
    localparam logic [21:0] RST_P1 = 22'd0;

    int a_hs_lo, a_vs_lo, a_act_n, a_ls_n, a_fs_n, b_tick_n, d_ls_n, d_hs_lo, n;

    initial begin
        a_hs_lo = 0; a_vs_lo = 0; a_act_n = 0; a_ls_n = 0; a_fs_n = 0;
        b_tick_n = 0; d_ls_n = 0; d_hs_lo = 0;

        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        check("rst_a", 0, out_a, RST_P0);
        check("rst_b", 0, out_b, RST_P0);
        check("rst_c", 0, out_c, RST_P1);
        check("rst_d", 0, out_d, RST_P0);

        Reset = 1'b0;
        for (int k = 0; k < 3300; k++) begin
            @(negedge Clock);
            check("a_cyc", k, out_a, model(k, 1, 8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0, 0));
            check("b_cyc", k, out_b, model(k, 3, 8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0, 0));
            check("c_cyc", k, out_c, model(k, 1, 8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1, 0));
            check("d_cyc", k, out_d, model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2));
            if (k < 112) begin
                a_hs_lo += int'(!a_hs);
                a_vs_lo += int'(!a_vs);
                a_act_n += int'(a_act);
                a_ls_n  += int'(a_ls);
                a_fs_n  += int'(a_fs);
            end
            if (k < 42)   b_tick_n += int'(b_tick);
            if (k < 1600) d_hs_lo  += int'(!d_hs);
            d_ls_n += int'(d_ls);
            if (k == 9)    check("a_hs_pre", k, a_hs, 1'b1);
            if (k == 10)   check("a_hs_lead", k, a_hs, 1'b0);
            if (k == 12)   check("a_hs_last", k, a_hs, 1'b0);
            if (k == 13)   check("a_hs_post", k, a_hs, 1'b1);
            if (k == 69)   check("a_vs_pre", k, a_vs, 1'b1);
            if (k == 70)   check("a_vs_lead", k, a_vs, 1'b0);
            if (k == 97)   check("a_vs_last", k, a_vs, 1'b0);
            if (k == 98)   check("a_vs_post", k, a_vs, 1'b1);
            if (k == 111)  check("a_last_px", k, {a_act, a_fs, a_ls}, 3'b000);
            if (k == 112)  check("a_wrap", k, {a_fs, a_ls, a_act, a_col, a_row}, {3'b111, 16'd0});
            if (k == 10)   check("c_hs_inv", k, c_hs, 1'b1);
            if (k == 70)   check("c_vs_inv", k, c_vs, 1'b1);
            if (k == 3)    check("b_tick3", k, b_tick, 1'b1);
            if (k == 4)    check("b_tick4", k, b_tick, 1'b0);
            if (k == 41)   check("b_ls41", k, b_ls, 1'b0);
            if (k == 42)   check("b_ls42", k, b_ls, 1'b1);
            if (k == 1278) check("d_col639", k, d_col, 8'd159);
            if (k == 1280) check("d_col640", k, {d_act, d_col}, 9'd0);
            if (k == 1600) check("d_line2", k, d_ls, 1'b1);
        end
        check("a_hs_low_cnt", -1, a_hs_lo, 24);
        check("a_vs_low_cnt", -1, a_vs_lo, 28);
        check("a_active_cnt", -1, a_act_n, 32);
        check("a_ls_cnt", -1, a_ls_n, 8);
        check("a_fs_cnt", -1, a_fs_n, 1);
        check("b_tick_cnt", -1, b_tick_n, 14);
        check("d_hs_low_cnt", -1, d_hs_lo, 192);
        check("d_ls_cnt", -1, d_ls_n, 3);

        // Restart, run to line 2 pixel 5, then reset mid-frame.
        Reset = 1'b1;
        @(negedge Clock);
        check("rst2_a", 0, out_a, RST_P0);
        Reset = 1'b0;
        for (int k = 0; k <= 33; k++) begin
            @(negedge Clock);
            if (k == 0)  check("a_restart", k, {a_fs, a_act, a_col, a_row}, {2'b11, 16'd0});
            if (k == 33) check("a_l2p5", k, {a_act, a_col, a_row}, {1'b1, 8'd5, 8'd2});
        end
        Reset = 1'b1;
        @(negedge Clock);
        check("midrst_a", 0, out_a, RST_P0);
        check("midrst_c", 0, out_c, RST_P1);
        Reset = 1'b0;
        @(negedge Clock);
        check("postrst_a", 0, {a_fs, a_ls, a_act, a_col, a_row}, {3'b111, 16'd0});
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!a_fs && n < 200);
        check("a_frame_len", -1, n, 112);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator for all display paths. Produces horizontal and vertical sync, a video-active qualifier, scaled video-memory column/row addresses, and line/frame start strobes. It runs from the system Clock with an internal pixel-rate prescaler. Vertical timing is counted in lines, not clocks. Porch, sync widths, polarities and memory scaling are all parameters, so the same block serves 640x480 and reduced test modes.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: horizontal sync width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vertical sync width, in lines
- V_BP, 33: vertical back porch, in lines
- HS_POL, 0: asserted level of oVGAHorizontalSync (0 = active-low)
- VS_POL, 0: asserted level of oVGAVerticalSync
- CLK_DIV, 2: Clock cycles per pixel, ≥1
- SCALE_SHIFT, 0: memory address = pixel coordinate >> SCALE_SHIFT
- X_WIDTH, 8: width of oVideoMemCol
- Y_WIDTH, 8: width of oVideoMemRow
- Clock  in  1  system clock
- Reset  in  1  reset, synchronous, active-high; clock Clock
- oVGAHorizontalSync  out  1  horizontal sync, level per HS_POL
- oVGAVerticalSync  out  1  vertical sync, level per VS_POL
- oVideoActive  out  1  high while the current pixel is inside both active regions
- oVideoMemCol  out  X_WIDTH  scaled column address
- oVideoMemRow  out  Y_WIDTH  scaled row address
- oPixelTick  out  1  one-Clock strobe; outputs have just advanced to a new pixel
- oLineStart  out  1  strobe coincident with pixel 0 of every line
- oFrameStart  out  1  strobe coincident with pixel (0,0) of every frame

## Operation
- **Prescaler:** counts 0..CLK_DIV-1. The pixel step occurs when the count reaches CLK_DIV-1. With CLK_DIV=1, every cycle is a step.
- **Horizontal FSM:** states H_ACT → H_FP → H_SYN → H_BP → H_ACT. The counter resets to 0 on each state change. Each state lasts exactly its parameter in pixels.
- **Vertical FSM:** states V_ACT → V_FP → V_SYN → V_BP → V_ACT. It advances only on the pixel step that leaves H_BP (the line wrap). Each state lasts exactly its parameter in lines.
- **Sync outputs:** oVGAHorizontalSync = HS_POL while in H_SYN, otherwise ~HS_POL. oVGAVerticalSync = VS_POL for whole lines in V_SYN, otherwise ~VS_POL. Vsync edges align with line start.
- **oVideoActive:** high iff H_ACT && V_ACT.
- **oVideoMemCol:** (hcount >> SCALE_SHIFT), truncated to X_WIDTH, while oVideoActive; otherwise 0.
- **oVideoMemRow:** (vcount >> SCALE_SHIFT), truncated to Y_WIDTH, while in V_ACT; otherwise 0.
- **Frame wrap:** the last pixel of the last V_BP line steps to (H_ACT 0, V_ACT 0) and asserts oLineStart and oFrameStart.
- **Internal counter width:** $clog2 of the maximum phase length plus 1. No overflow is permitted for any legal parameter set.

## Timing
- **During Reset:** both syncs inactive (~POL), oVideoActive=0, col=row=0, all strobes 0. Prescaler and FSMs return to H_ACT/V_ACT count 0.
- **First Clock edge with Reset low:** all outputs are registered.
  - oVideoActive=1, col=row=0.
  - oPixelTick=oLineStart=oFrameStart=1.
- **Pixel period:** each subsequent pixel appears CLK_DIV cycles after the previous one. oPixelTick is high on exactly the first cycle of each pixel, and outputs are stable for CLK_DIV cycles. CLK_DIV=1 gives oPixelTick constantly 1 after reset.
- **Periods:** line period = (H_ACTIVE+H_FP+H_SYNC+H_BP)·CLK_DIV cycles. Frame period = line period · (V_ACTIVE+V_FP+V_SYNC+V_BP).
- **Reset mid-line or mid-frame:** takes effect on the next edge, with no partial sync pulse after release. The frame restarts as above.
- **Line and frame strobes:** oLineStart also fires on lines inside vertical blanking. oFrameStart fires only at the frame wrap and after reset.

## Structure
- Package vga_timing_pkg holds:
  - the four-phase state enum (ACT, FP, SYN, BP) shared by both axes;
  - 640x480 default timing constants;
  - a phase-length helper function.
- Sub-module vga_axis_counter: parametrised by four phase lengths, with inputs step enable and Clock/Reset. Outputs are phase, count and wrap. It is instantiated twice:
  - H: step = pixel step;
  - V: step = H wrap.
- Top level contains the prescaler, the output register stage and the polarity/scaling logic.

## Test plan
- **Small mode:** H 8/2/3/1, V 4/1/2/1, CLK_DIV=1, pols 0.
  - Line = 14 cycles; hsync low on cycles 10–12 of each line.
  - Frame = 112 cycles; vsync low for lines 5–6 (28 cycles).
  - oVideoActive on 32 cycles per frame.
- **CLK_DIV=3, same mode:** oPixelTick every 3rd cycle; line = 42 cycles; outputs stable within each 3-cycle pixel.
- **HS_POL=1, VS_POL=1:** sync waveforms are the exact inversion of the first scenario; the reset level is 0.
- **Default 640x480, SCALE_SHIFT=2, CLK_DIV=2:**
  - line = 1600 cycles, frame = 840000 cycles;
  - col sequence 0,0,0,0,1,… reaches 159 at pixel 639;
  - row reaches 119 on line 479.
- **Reset mid-frame:** assert Reset at line 2, pixel 5 of the small mode.
  - All outputs take reset values.
  - After release, oFrameStart=1 with col=row=0, and the next frame is exactly 112 cycles.
- **Frame wrap:** at the last pixel of the final V_BP line, the next step gives oLineStart=oFrameStart=1 and oVideoActive=1 at (0,0).
